tqv_peripheral_harness: RTL and testbench



---
 rtl/tqv_peripheral_harness.sv | 259 +++++++++++++++++++++++++
 tb/tb_tqv_peripheral_harness.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tqv_peripheral_harness.sv
// -----------------------------------------------------------------------------
// tqv_peripheral_harness
//
// Tiny Tapeout harness around an NES game-controller reader. A mode-0 SPI
// slave on the uio pins gives register access. The scan engine drives the
// controller LATCH/CLK lines and shifts in its serial button data.
//
// Ports
//   clk      in   system clock (only clock domain)
//   rst_n    in   synchronous active-low reset
//   ena      in   design selected (ignored)
//   ui_in    in   [1] nes_data from controller (active-low buttons)
//   uo_out   out  [7] nes_clk, [6] nes_latch, [0] irq (= data_ready), rest 0
//   uio_in   in   [0] spi_cs_n, [1] spi_mosi, [3] spi_sck
//   uio_out  out  [2] spi_miso, rest 0
//   uio_oe   out  constant 8'b0000_0100 (only MISO is driven)
//
// Register map (4-bit address)
//   0x0 BUTTONS (R)   1 = pressed; reading clears data_ready
//   0x1 CTRL    (R/W) bit0 auto-poll enable, bit1 start (self-clearing)
//   0x2 STATUS  (R)   bit0 busy, bit1 data_ready
// -----------------------------------------------------------------------------
module tqv_peripheral_harness #(
  parameter int HALF_PERIOD = 8,
  parameter int IDLE_GAP    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] LATCH_LAST = 16'(2 * HALF_PERIOD - 1);
  localparam logic [15:0] HALF_LAST  = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_LO,
    S_CLK_HI,
    S_DONE,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Index [1] is the synchronised value; index [2] of the
  // cs/sck chains is its one-cycle-old copy for edge detection. MOSI uses the
  // same depth as SCK so the two stay aligned.
  // ---------------------------------------------------------------------------
  logic [2:0] r_cs_sync;
  logic [2:0] r_sck_sync;
  logic [1:0] r_mosi_sync;
  logic [1:0] r_nes_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs_sync   <= 3'b111;
      r_sck_sync  <= 3'b000;
      r_mosi_sync <= 2'b00;
      r_nes_sync  <= 2'b11;
    end else begin
      r_cs_sync   <= {r_cs_sync[1:0], uio_in[0]};
      r_sck_sync  <= {r_sck_sync[1:0], uio_in[3]};
      r_mosi_sync <= {r_mosi_sync[0], uio_in[1]};
      r_nes_sync  <= {r_nes_sync[0], ui_in[1]};
    end
  end

  logic w_cs_act, w_cs_fall, w_sck_rise, w_sck_fall, w_mosi, w_nes;
  assign w_cs_act   = ~r_cs_sync[1];
  assign w_cs_fall  = r_cs_sync[2] & ~r_cs_sync[1];
  assign w_sck_rise = ~r_sck_sync[2] & r_sck_sync[1];
  assign w_sck_fall = r_sck_sync[2] & ~r_sck_sync[1];
  assign w_mosi     = r_mosi_sync[1];
  assign w_nes      = r_nes_sync[1];

  // ---------------------------------------------------------------------------
  // SPI frame handling
  // ---------------------------------------------------------------------------
  logic [4:0] r_bit_cnt;
  logic [6:0] r_sh;
  logic       r_is_wr;
  logic [3:0] r_addr;
  logic [7:0] r_rd_sh;
  logic       r_miso;
  logic       r_ctrl_en;
  logic [7:0] r_buttons;
  logic       r_data_ready;

  state_t     r_state, w_state_next;

  logic       w_bit_rise, w_latch_rd, w_commit, w_start, w_rd_btn, w_busy;
  logic [7:0] w_word;
  logic [7:0] w_rdata;

  // Bits beyond the 16th of a frame are ignored (counter saturates at 16).
  assign w_bit_rise = w_sck_rise & w_cs_act & ~w_cs_fall & ~r_bit_cnt[4];
  // The byte completed by the current rising edge: header at bit 8, data at 16.
  assign w_word     = {r_sh, w_mosi};
  assign w_latch_rd = w_bit_rise & (r_bit_cnt == 5'd7);
  assign w_commit   = w_bit_rise & (r_bit_cnt == 5'd15) & r_is_wr;
  assign w_start    = w_commit & (r_addr == 4'h1) & w_word[1];
  // The BUTTONS value is consumed when it is captured for shifting out.
  assign w_rd_btn   = w_latch_rd & ~w_word[7] & (w_word[3:0] == 4'h0);
  assign w_busy     = (r_state != S_IDLE) && (r_state != S_GAP);

  always_comb begin
    w_rdata = 8'h00;
    if (!w_word[7]) begin
      case (w_word[3:0])
        4'h0:    w_rdata = r_buttons;
        4'h1:    w_rdata = {7'b0, r_ctrl_en};
        4'h2:    w_rdata = {6'b0, r_data_ready, w_busy};
        default: w_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt <= 5'd0;
      r_sh      <= 7'd0;
      r_is_wr   <= 1'b0;
      r_addr    <= 4'h0;
      r_rd_sh   <= 8'h00;
      r_miso    <= 1'b0;
      r_ctrl_en <= 1'b0;
    end else begin
      if (w_cs_fall) begin
        r_bit_cnt <= 5'd0;
        r_miso    <= 1'b0;
      end else if (!w_cs_act) begin
        // Deselected: MISO parked low, any partial frame is dropped.
        r_bit_cnt <= 5'd0;
        r_miso    <= 1'b0;
      end else begin
        if (w_bit_rise) begin
          r_sh      <= w_word[6:0];
          r_bit_cnt <= r_bit_cnt + 5'd1;
          if (r_bit_cnt == 5'd7) begin
            r_is_wr <= w_word[7];
            r_addr  <= w_word[3:0];
            r_rd_sh <= w_rdata;
          end
        end
        // Read data goes out on the falling edges that precede bits 7..0.
        if (w_sck_fall && (r_bit_cnt >= 5'd8) && (r_bit_cnt <= 5'd15)) begin
          r_miso  <= r_rd_sh[7];
          r_rd_sh <= {r_rd_sh[6:0], 1'b0};
        end
      end
      if (w_commit && (r_addr == 4'h1)) begin
        r_ctrl_en <= w_word[0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  logic [15:0] r_cnt, w_cnt_next;
  logic [2:0]  r_bit_idx, w_bit_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        r_nes_latch, r_nes_clk;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 16'd1;
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = 16'd0;
        if (r_ctrl_en || w_start) begin
          w_state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        if (r_cnt == LATCH_LAST) begin
          w_state_next = S_CLK_LO;
          w_cnt_next   = 16'd0;
          w_bit_next   = 3'd0;
        end
      end
      S_CLK_LO: begin
        if (r_cnt == HALF_LAST) begin
          w_shift_next[r_bit_idx] = w_nes;
          w_cnt_next              = 16'd0;
          // No clock pulse after the last bit.
          w_state_next = (r_bit_idx == 3'd7) ? S_DONE : S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        if (r_cnt == HALF_LAST) begin
          w_state_next = S_CLK_LO;
          w_cnt_next   = 16'd0;
          w_bit_next   = r_bit_idx + 3'd1;
        end
      end
      S_DONE: begin
        w_cnt_next   = 16'd0;
        w_state_next = r_ctrl_en ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (!r_ctrl_en) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 16'd0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_next = S_LATCH;
          w_cnt_next   = 16'd0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_nes_latch  <= 1'b0;
      r_nes_clk    <= 1'b0;
      r_buttons    <= 8'h00;
      r_data_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_idx   <= w_bit_next;
      r_shift     <= w_shift_next;
      // Registered from next state so the pins are glitch-free.
      r_nes_latch <= (w_state_next == S_LATCH);
      r_nes_clk   <= (w_state_next == S_CLK_HI);
      if (r_state == S_DONE) begin
        r_buttons    <= ~r_shift;
        r_data_ready <= 1'b1;        // set wins over a coincident read-clear
      end else if (w_rd_btn) begin
        r_data_ready <= 1'b0;
      end
    end
  end

  assign uo_out  = {r_nes_clk, r_nes_latch, 5'b00000, r_data_ready};
  assign uio_out = {5'b00000, r_miso, 2'b00};
  assign uio_oe  = 8'b0000_0100;

  logic w_unused;
  assign w_unused = &{1'b0, ena, ui_in[7:2], ui_in[0], uio_in[7:4], uio_in[2]};

endmodule

// File: tb/tb_tqv_peripheral_harness.sv
// -----------------------------------------------------------------------------
// tb_tqv_peripheral_harness
//
// Directed bench for the NES controller harness. Stimulus pushes the expected
// value of each observation into a queue; a monitor on the falling clock edge
// pops observations and compares them against the expected queue in order.
// A small behavioural NES pad shifts out a configurable serial pattern.
// -----------------------------------------------------------------------------
module tb_tqv_peripheral_harness;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       cs_n = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] pad = 8'hFF;     // serial pattern, bit0 shifted first
  int         pad_idx = 0;
  logic       nes_data;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  assign nes_data = (pad_idx > 7) ? 1'b1 : pad[pad_idx[2:0]];
  assign ui_in    = {6'b0, nes_data, 1'b0};
  assign uio_in   = {4'b0, sck, 1'b0, mosi, cs_n};

  always #5 clk = ~clk;

  tqv_peripheral_harness #(.HALF_PERIOD(8), .IDLE_GAP(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Pulse statistics and pad model
  int   cyc = 0, latch_cnt = 0, latch_hi = 0, clk_cnt = 0, clk_hi = 0;
  int   last_rise = 0, prev_rise = 0;
  logic p_latch = 1'b0, p_nclk = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (uo_out[6] && !p_latch) begin
      latch_cnt = latch_cnt + 1;
      prev_rise = last_rise;
      last_rise = cyc;
      pad_idx   = 0;
    end
    if (uo_out[7] && !p_nclk) begin
      clk_cnt = clk_cnt + 1;
      pad_idx = pad_idx + 1;
    end
    if (uo_out[6]) latch_hi = latch_hi + 1;
    if (uo_out[7]) clk_hi = clk_hi + 1;
    p_latch = uo_out[6];
    p_nclk  = uo_out[7];
  end

  // Scoreboard
  string       exp_name_q[$];
  logic [15:0] exp_val_q[$];
  logic [15:0] obs_q[$];
  int          n_cmp = 0, n_err = 0;
  logic [15:0] mon_got, mon_exp;
  string       mon_name;

  task automatic expect_val(input string name, input logic [15:0] v);
    exp_name_q.push_back(name);
    exp_val_q.push_back(v);
  endtask

  task automatic observe(input logic [15:0] v);
    obs_q.push_back(v);
  endtask

  always @(negedge clk) begin
    while (obs_q.size() > 0) begin
      mon_got = obs_q.pop_front();
      n_cmp   = n_cmp + 1;
      if (exp_val_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_observation got=%h required=nothing", mon_got);
      end else begin
        mon_exp  = exp_val_q.pop_front();
        mon_name = exp_name_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_err = n_err + 1;
          $display("FAIL %s got=%h required=%h", mon_name, mon_got, mon_exp);
        end else begin
          $display("ok   %s = %h", mon_name, mon_got);
        end
      end
    end
  end

  // SPI host, mode 0, sck = clk/8
  task automatic spi_xfer(input logic [15:0] f, input int nbits, output logic [7:0] rd);
    rd   = 8'h00;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = f[15-i];
      repeat ((i == 0) ? 2 : 4) @(negedge clk);
      if (i >= 8) rd[15-i] = uio_out[2];
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic spi_write(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    spi_xfer({4'b1000, a, d}, 16, dummy);
  endtask

  task automatic spi_read(input string name, input logic [3:0] a, input logic [7:0] e);
    logic [7:0] r;
    expect_val(name, {8'h00, e});
    spi_xfer({4'b0000, a, 8'h00}, 16, r);
    observe({8'h00, r});
  endtask

  task automatic wait_irq(input int maxc);
    int n = 0;
    while (!uo_out[0] && n < maxc) begin
      @(negedge clk);
      n++;
    end
    expect_val("irq_set", 16'h0001);
    observe({15'b0, uo_out[0]});
  endtask

  task automatic wait_latches(input int k, input int maxc);
    int base = latch_cnt;
    int n = 0;
    while ((latch_cnt - base) < k && n < maxc) begin
      @(negedge clk);
      n++;
    end
    expect_val("latch_seen", 16'h0001);
    observe({15'b0, ((latch_cnt - base) >= k)});
  endtask

  int         bl, bh, bc, bch, n;
  logic [7:0] dummy8;

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    expect_val("rst_uo_out", 16'h0000);  observe({8'h00, uo_out});
    expect_val("rst_uio_oe", 16'h0004);  observe({8'h00, uio_oe});
    expect_val("rst_uio_out", 16'h0000); observe({8'h00, uio_out});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    spi_read("rst_buttons", 4'h0, 8'h00);
    spi_read("rst_status", 4'h2, 8'h00);

    // One-shot scan
    pad = 8'b1010_0110;
    bl = latch_cnt; bh = latch_hi; bc = clk_cnt; bch = clk_hi;
    spi_write(4'h1, 8'h02);
    wait_irq(400);
    repeat (4) @(negedge clk);
    expect_val("latch_pulses", 16'd1);  observe(16'(latch_cnt - bl));
    expect_val("latch_width", 16'd16);  observe(16'(latch_hi - bh));
    expect_val("clk_pulses", 16'd7);    observe(16'(clk_cnt - bc));
    expect_val("clk_high_total", 16'd56); observe(16'(clk_hi - bch));
    spi_read("status_done", 4'h2, 8'h02);
    spi_read("ctrl_selfclr", 4'h1, 8'h00);
    spi_read("buttons", 4'h0, 8'h59);
    spi_read("status_cleared", 4'h2, 8'h00);
    expect_val("irq_cleared", 16'h0000); observe({15'b0, uo_out[0]});

    // Busy flag visible mid-scan
    pad = 8'h3C;
    spi_write(4'h1, 8'h02);
    spi_read("status_busy", 4'h2, 8'h01);
    wait_irq(400);
    spi_read("buttons_3c", 4'h0, 8'hC3);

    // Second start while busy is ignored
    bl = latch_cnt;
    spi_write(4'h1, 8'h02);
    spi_write(4'h1, 8'h02);
    wait_irq(400);
    repeat (250) @(negedge clk);
    expect_val("double_start_latches", 16'd1); observe(16'(latch_cnt - bl));
    spi_read("buttons_again", 4'h0, 8'hC3);

    // Auto-poll
    pad = 8'hFF;
    spi_write(4'h1, 8'h01);
    wait_latches(3, 1000);
    expect_val("poll_period", 16'd201); observe(16'(last_rise - prev_rise));
    spi_read("ctrl_auto", 4'h1, 8'h01);
    spi_read("buttons_none", 4'h0, 8'h00);
    pad = 8'h00;
    wait_latches(1, 400);
    repeat (150) @(negedge clk);
    spi_read("buttons_all", 4'h0, 8'hFF);
    spi_write(4'h1, 8'h00);
    repeat (200) @(negedge clk);
    bl = latch_cnt;
    repeat (500) @(negedge clk);
    expect_val("auto_stopped", 16'd0); observe(16'(latch_cnt - bl));

    // Aborted frames and unmapped address
    bl = latch_cnt;
    spi_xfer(16'h8103, 10, dummy8);
    spi_read("ctrl_abort10", 4'h1, 8'h00);
    spi_xfer(16'h8103, 15, dummy8);
    spi_read("ctrl_abort15", 4'h1, 8'h00);
    repeat (50) @(negedge clk);
    expect_val("abort_no_scan", 16'd0); observe(16'(latch_cnt - bl));
    spi_read("unmapped_7", 4'h7, 8'h00);

    // Reset in the middle of a scan
    spi_write(4'h1, 8'h02);
    n = 0;
    while (!uo_out[7] && n < 200) begin
      @(negedge clk);
      n++;
    end
    expect_val("nes_clk_seen", 16'h0001); observe({15'b0, uo_out[7]});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    expect_val("rst_mid_uo_out", 16'h0000); observe({8'h00, uo_out});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bl = latch_cnt;
    repeat (300) @(negedge clk);
    expect_val("rst_no_rescan", 16'd0); observe(16'(latch_cnt - bl));
    spi_read("rst_mid_status", 4'h2, 8'h00);
    spi_read("rst_mid_buttons", 4'h0, 8'h00);

    repeat (3) @(negedge clk);
    if (exp_val_q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL pending_expectations got=%0d required=0", exp_val_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
